// File: rtl/unidade_load_store_if.sv
// Request, response and data-memory bus of the load/store unit.
interface unidade_load_store_if;
   localparam int unsigned BITS_PALAVRA  = 16;
   localparam int unsigned END_REGISTROS = 16;

   logic                     req_valido;
   logic                     req_pronto;
   logic                     req_escrita;
   logic                     req_byte;
   logic                     req_meio;
   logic                     req_sinal;
   logic [END_REGISTROS-1:0] req_end;
   logic [BITS_PALAVRA-1:0]  req_dado;
   logic                     resp_valido;
   logic [BITS_PALAVRA-1:0]  resp_dado;
   logic                     mem_hab_escrita;
   logic [END_REGISTROS-1:0] mem_endereco;
   logic [BITS_PALAVRA-1:0]  mem_entrada;
   logic [BITS_PALAVRA-1:0]  mem_saida;

   // Environment side: execute stage issuing requests plus the data memory.
   modport master (
      output req_valido, req_escrita, req_byte, req_meio, req_sinal, req_end, req_dado,
      input  req_pronto, resp_valido, resp_dado,
      input  mem_hab_escrita, mem_endereco, mem_entrada,
      output mem_saida
   );

   // Load/store unit side.
   modport slave (
      input  req_valido, req_escrita, req_byte, req_meio, req_sinal, req_end, req_dado,
      output req_pronto, resp_valido, resp_dado,
      output mem_hab_escrita, mem_endereco, mem_entrada,
      input  mem_saida
   );
endinterface

// File: rtl/unidade_load_store.sv
// Load/store unit: one request at a time, byte loads with extension,
// byte stores as read-modify-write of the addressed 16-bit word.
module unidade_load_store (
   input  logic                 clock_i,
   input  logic                 reset_i,
   unidade_load_store_if.slave  ls
);
   localparam int unsigned BITS_PALAVRA  = 16;
   localparam int unsigned END_REGISTROS = 16;
   localparam int unsigned BITS_BYTE     = 8;

   typedef enum logic [1:0] {OCIOSO, LEITURA, CAPTURA, ESCRITA} estado_t;

   estado_t                  estado_q;
   logic                     escrita_q;
   logic                     byte_q;
   logic                     meio_q;
   logic                     sinal_q;
   logic [BITS_BYTE-1:0]     dado_q;
   logic                     resp_valido_q;
   logic [BITS_PALAVRA-1:0]  resp_dado_q;
   logic                     hab_escrita_q;
   logic [END_REGISTROS-1:0] endereco_q;
   logic [BITS_PALAVRA-1:0]  entrada_q;

   logic [BITS_BYTE-1:0]     byte_sel_c;
   logic [BITS_PALAVRA-1:0]  resp_dado_d;
   logic [BITS_PALAVRA-1:0]  entrada_byte_d;

   // Lane selection, load extension and byte merge from the memory read word.
   always_comb begin
      byte_sel_c     = meio_q ? ls.mem_saida[15:8] : ls.mem_saida[7:0];
      resp_dado_d    = ls.mem_saida;
      if (byte_q) begin
         resp_dado_d = {(sinal_q ? {BITS_BYTE{byte_sel_c[BITS_BYTE-1]}} : {BITS_BYTE{1'b0}}),
                        byte_sel_c};
      end
      entrada_byte_d = meio_q ? {dado_q, ls.mem_saida[7:0]}
                              : {ls.mem_saida[15:8], dado_q};
   end

   // Request sequencing and all registered outputs.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         estado_q      <= OCIOSO;
         escrita_q     <= 1'b0;
         byte_q        <= 1'b0;
         meio_q        <= 1'b0;
         sinal_q       <= 1'b0;
         dado_q        <= '0;
         resp_valido_q <= 1'b0;
         resp_dado_q   <= '0;
         hab_escrita_q <= 1'b0;
         endereco_q    <= '0;
         entrada_q     <= '0;
      end else begin
         resp_valido_q <= 1'b0;
         hab_escrita_q <= 1'b0;
         case (estado_q)
            OCIOSO: begin
               if (ls.req_valido) begin
                  escrita_q  <= ls.req_escrita;
                  byte_q     <= ls.req_byte;
                  meio_q     <= ls.req_meio;
                  sinal_q    <= ls.req_sinal;
                  dado_q     <= ls.req_dado[7:0];
                  endereco_q <= ls.req_end;
                  if (ls.req_escrita && !ls.req_byte) begin
                     entrada_q     <= ls.req_dado;
                     hab_escrita_q <= 1'b1;
                     estado_q      <= ESCRITA;
                  end else begin
                     estado_q <= LEITURA;
                  end
               end
            end
            LEITURA: estado_q <= CAPTURA;
            CAPTURA: begin
               if (escrita_q) begin
                  entrada_q     <= entrada_byte_d;
                  hab_escrita_q <= 1'b1;
                  estado_q      <= ESCRITA;
               end else begin
                  resp_dado_q   <= resp_dado_d;
                  resp_valido_q <= 1'b1;
                  estado_q      <= OCIOSO;
               end
            end
            ESCRITA: estado_q <= OCIOSO;
            default: estado_q <= OCIOSO;
         endcase
      end
   end

   // Ready and write enable are also masked by reset so nothing leaks while it is held.
   assign ls.req_pronto      = (estado_q == OCIOSO) && !reset_i;
   assign ls.mem_hab_escrita = hab_escrita_q && !reset_i;
   assign ls.mem_endereco    = endereco_q;
   assign ls.mem_entrada     = entrada_q;
   assign ls.resp_valido     = resp_valido_q;
   assign ls.resp_dado       = resp_dado_q;
endmodule

// File: tb/tb_unidade_load_store.sv
// Randomized and directed bench for unidade_load_store with a word-level memory model.
module tb_unidade_load_store;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   wr_cnt   = 0;

   bit [15:0]   mem     [0:65535];
   bit          written [0:65535];
   logic [15:0] ref_mem [logic [15:0]];

   unidade_load_store_if bus ();

   unidade_load_store dut (
      .clock_i (clk),
      .reset_i (rst),
      .ls      (bus)
   );

   always #5 clk = ~clk;

   // Data memory: preloaded word[i] = i, registered read, write at the closing edge.
   always @(posedge clk) begin
      if (bus.mem_hab_escrita) begin
         mem[bus.mem_endereco]     <= bus.mem_entrada;
         written[bus.mem_endereco] <= 1'b1;
         wr_cnt                    <= wr_cnt + 1;
      end
      bus.mem_saida <= written[bus.mem_endereco] ? mem[bus.mem_endereco] : bus.mem_endereco;
   end

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ref_rd(input logic [15:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : a;
   endfunction

   // Present a request at a negedge and return just after its accept edge, valid still high.
   task automatic send(input bit esc, input bit byt, input bit meio, input bit sinal,
                       input logic [15:0] a, input logic [15:0] d);
      bus.req_escrita = esc;
      bus.req_byte    = byt;
      bus.req_meio    = meio;
      bus.req_sinal   = sinal;
      bus.req_end     = a;
      bus.req_dado    = d;
      bus.req_valido  = 1'b1;
      for (int k = 0; k < 50 && !bus.req_pronto; k++) @(negedge clk);
      if (!bus.req_pronto) begin
         check_eq("accept_timeout", 16'(bus.req_pronto), 16'd1);
         $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
         $finish;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic finish_load(input logic [15:0] exp, input string tag);
      int w0 = wr_cnt;
      @(negedge clk);
      check_eq({tag, "_valid_n"}, 16'(bus.resp_valido), 16'd0);
      check_eq({tag, "_busy_n"}, 16'(bus.req_pronto), 16'd0);
      @(negedge clk);
      check_eq({tag, "_valid_n1"}, 16'(bus.resp_valido), 16'd0);
      @(negedge clk);
      check_eq({tag, "_valid_n2"}, 16'(bus.resp_valido), 16'd1);
      check_eq({tag, "_data"}, bus.resp_dado, exp);
      check_eq({tag, "_ready_n2"}, 16'(bus.req_pronto), 16'd1);
      check_eq({tag, "_no_write"}, 16'(wr_cnt - w0), 16'd0);
   endtask

   task automatic finish_store(input bit byt, input logic [15:0] a, input logic [15:0] exp,
                               input string tag);
      int w0 = wr_cnt;
      if (byt) begin
         @(negedge clk);
         check_eq({tag, "_we_n"}, 16'(bus.mem_hab_escrita), 16'd0);
         check_eq({tag, "_busy_n"}, 16'(bus.req_pronto), 16'd0);
         @(negedge clk);
         check_eq({tag, "_we_n1"}, 16'(bus.mem_hab_escrita), 16'd0);
      end
      @(negedge clk);
      check_eq({tag, "_we"}, 16'(bus.mem_hab_escrita), 16'd1);
      check_eq({tag, "_addr"}, bus.mem_endereco, a);
      check_eq({tag, "_wdata"}, bus.mem_entrada, exp);
      check_eq({tag, "_busy_we"}, 16'(bus.req_pronto), 16'd0);
      @(negedge clk);
      check_eq({tag, "_ready"}, 16'(bus.req_pronto), 16'd1);
      check_eq({tag, "_we_off"}, 16'(bus.mem_hab_escrita), 16'd0);
      check_eq({tag, "_one_write"}, 16'(wr_cnt - w0), 16'd1);
      check_eq({tag, "_mem"}, mem[a], exp);
   endtask

   // One complete transaction checked against the reference word memory.
   task automatic op(input bit esc, input bit byt, input bit meio, input bit sinal,
                     input logic [15:0] a, input logic [15:0] d, input string tag);
      int w = int'(ref_rd(a));
      int b = meio ? (w >> 8) & 255 : w & 255;
      int e;
      if (!esc) begin
         if (!byt)                 e = w;
         else if (sinal && b >= 128) e = b + 'hFF00;
         else                      e = b;
         send(esc, byt, meio, sinal, a, d);
         bus.req_valido = 1'b0;
         finish_load(16'(e), tag);
      end else begin
         if (!byt)      e = int'(d);
         else if (meio) e = (w & 'h00FF) + ((int'(d) & 255) << 8);
         else           e = (w & 'hFF00) + (int'(d) & 255);
         send(esc, byt, meio, sinal, a, d);
         bus.req_valido = 1'b0;
         finish_store(byt, a, 16'(e), tag);
         ref_mem[a] = 16'(e);
      end
   endtask

   initial begin
      int w0;
      rst             = 1'b1;
      bus.req_valido  = 1'b0;
      bus.req_escrita = 1'b0;
      bus.req_byte    = 1'b0;
      bus.req_meio    = 1'b0;
      bus.req_sinal   = 1'b0;
      bus.req_end     = '0;
      bus.req_dado    = '0;

      repeat (3) @(negedge clk);
      check_eq("rst_ready_low", 16'(bus.req_pronto), 16'd0);
      check_eq("rst_we_low", 16'(bus.mem_hab_escrita), 16'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_ready", 16'(bus.req_pronto), 16'd1);
      check_eq("rst_resp_valid", 16'(bus.resp_valido), 16'd0);
      check_eq("rst_resp_data", bus.resp_dado, 16'h0000);
      check_eq("rst_we", 16'(bus.mem_hab_escrita), 16'd0);
      check_eq("rst_addr", bus.mem_endereco, 16'h0000);
      check_eq("rst_wdata", bus.mem_entrada, 16'h0000);

      op(1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, "ld_word_1234");
      op(1'b0, 1'b1, 1'b0, 1'b1, 16'h80F0, 16'h0000, "ld_b0_signed");
      op(1'b0, 1'b1, 1'b1, 1'b0, 16'h80F0, 16'h0000, "ld_b1_unsigned");
      op(1'b0, 1'b1, 1'b0, 1'b1, 16'h0055, 16'h0000, "ld_b0_signed_pos");
      op(1'b1, 1'b1, 1'b1, 1'b0, 16'h0055, 16'h00AB, "st_byte_lane1");
      op(1'b0, 1'b0, 1'b0, 1'b0, 16'h0055, 16'h0000, "ld_after_stb");
      op(1'b0, 1'b1, 1'b1, 1'b1, 16'h0055, 16'h0000, "ld_b1_signed_neg");

      // Word store followed by a load held on the bus the whole time.
      send(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'hBEEF);
      bus.req_escrita = 1'b0;
      @(negedge clk);
      check_eq("hs_busy_n", 16'(bus.req_pronto), 16'd0);
      check_eq("hs_we_n", 16'(bus.mem_hab_escrita), 16'd1);
      @(negedge clk);
      check_eq("hs_ready_n1", 16'(bus.req_pronto), 16'd1);
      check_eq("hs_mem", mem[16'h0010], 16'hBEEF);
      ref_mem[16'h0010] = 16'hBEEF;
      @(posedge clk);
      #1;
      bus.req_valido = 1'b0;
      finish_load(16'hBEEF, "hs_load");

      // Reset during the capture cycle of a byte store drops the write.
      w0 = wr_cnt;
      send(1'b1, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0077);
      bus.req_valido = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      check_eq("abort_we_comb", 16'(bus.mem_hab_escrita), 16'd0);
      check_eq("abort_ready_comb", 16'(bus.req_pronto), 16'd0);
      @(negedge clk);
      check_eq("abort_ready", 16'(bus.req_pronto), 16'd0);
      check_eq("abort_we", 16'(bus.mem_hab_escrita), 16'd0);
      check_eq("abort_resp_valid", 16'(bus.resp_valido), 16'd0);
      check_eq("abort_resp_data", bus.resp_dado, 16'h0000);
      check_eq("abort_addr", bus.mem_endereco, 16'h0000);
      check_eq("abort_wdata", bus.mem_entrada, 16'h0000);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("abort_ready_after", 16'(bus.req_pronto), 16'd1);
      check_eq("abort_no_write", 16'(wr_cnt - w0), 16'd0);
      check_eq("abort_resp_quiet", 16'(bus.resp_valido), 16'd0);
      op(1'b0, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, "ld_after_abort");

      // Random mix over a small hot address set plus occasional far addresses.
      for (int i = 0; i < 300; i++) begin
         logic [15:0] a;
         a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom), "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/unidade_load_store.md
# unidade_load_store

Load/store unit between the execute stage and the 16-bit data memory. Accepts one load or store request at a time over a valid/ready handshake and drives the memory's write enable, address and write-data inputs. Captures the memory's registered read word and returns load results with optional byte extraction and sign extension. Byte stores are done as read-modify-write on the addressed word.

## Interface
- bits_palavra, 16, data word width; byte lanes are [7:0] (lane 0) and [15:8] (lane 1).
- end_registros, 16, word-address width.
- clock  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- req_valido  in  1  request present; must hold it and all req_* fields stable until accepted.
- req_pronto  out  1  unit can accept; a request is accepted at a posedge where req_valido && req_pronto.
- req_escrita  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = full word.
- req_meio  in  1  byte lane for byte accesses (0 = [7:0], 1 = [15:8]); ignored for word accesses.
- req_sinal  in  1  byte loads: 1 = sign-extend, 0 = zero-extend.
- req_end  in  end_registros  word address.
- req_dado  in  bits_palavra  store data; byte stores use [7:0].
- resp_valido  out  1  one-cycle pulse, load result valid.
- resp_dado  out  bits_palavra  load result; held until the next load completes.
- mem_hab_escrita  out  1  memory write enable.
- mem_endereco  out  end_registros  memory address (registered).
- mem_entrada  out  bits_palavra  memory write data (registered).
- mem_saida  in  bits_palavra  memory read word; valid the cycle after mem_endereco is presented.

## Operation
- States: OCIOSO, LEITURA, CAPTURA, ESCRITA.
- req_pronto = 1 only in OCIOSO and not in reset. Requests presented in other states are not accepted.
- On accept, latch the request fields and load mem_endereco <= req_end.
- Transitions from OCIOSO:
  - word store -> ESCRITA, and mem_entrada <= req_dado.
  - load or byte store -> LEITURA.
- LEITURA -> CAPTURA. mem_hab_escrita = 0; the memory updates mem_saida at this edge.
- CAPTURA:
  - Load -> OCIOSO. resp_dado <= extracted value; resp_valido <= 1 for exactly one cycle.
  - Byte store -> ESCRITA. mem_entrada <= mem_saida with the selected lane replaced by the latched data[7:0]; the other lane is unchanged.
- ESCRITA -> OCIOSO. mem_hab_escrita = 1 for exactly this one cycle; the memory commits at the closing edge.
- Load extraction:
  - Word: mem_saida unchanged.
  - Byte: the selected lane in [7:0]; [15:8] = sign bit of that byte if req_sinal, else 0x00.
- mem_endereco and mem_entrada hold their last values in OCIOSO. mem_hab_escrita = 0 in every state except ESCRITA.
- Addresses are used as given: no wrap handling and no alignment checks.

## Timing
- Reset values: state OCIOSO, req_pronto 1 after release (0 while reset = 1), resp_valido 0, resp_dado 0, mem_hab_escrita 0, mem_endereco 0, mem_entrada 0.
- mem_hab_escrita is forced to 0 combinationally while reset = 1.
- Reset mid-operation aborts: a pending write is dropped, and no resp_valido pulse is issued for a pending load.
- All cycle numbers below count from the accept edge n.
- Word store: ESCRITA in cycle n..n+1, commit at edge n+1, req_pronto back at cycle n+1.
- Load: resp_valido high between edges n+2 and n+3; req_pronto is also 1 in that cycle, so back-to-back accepts are allowed.
- Byte store: commit at edge n+3.
- Throughput: one word store per 2 cycles; one load per 3 cycles; one byte store per 4 cycles.
- A load issued right after a store to the same address returns the new data, because the store commits before the load's LEITURA cycle.

## Test plan
- Memory preloaded with word[i] = i; after reset, check every output equals its reset value and req_pronto = 1.
- Word load of 0x1234 accepted at edge n -> resp_valido pulses one cycle starting at n+2 with resp_dado = 0x1234; no mem_hab_escrita pulse.
- Byte loads:
  - address 0x80F0, lane 0, signed -> resp_dado = 0xFFF0.
  - address 0x80F0, lane 1, unsigned -> resp_dado = 0x0080.
- Byte store of 0xAB to lane 1 of address 0x0055 -> a single write of 0xAB55 at edge n+3. A following word load returns 0xAB55.
- Word store of 0xBEEF to 0x0010 with req_valido held high throughout:
  - a second request (load 0x0010) is not accepted until cycle n+1;
  - the load returns 0xBEEF.
- Reset asserted during CAPTURA of a byte store -> no write occurs (word keeps its prior value); unit returns to OCIOSO with reset outputs.
